// File: rtl/dbus_sram_responder_pkg.sv
// Shared data-bus types and the responder state encoding.
package dbus_sram_responder_pkg;

   typedef enum logic [2:0] {
      MSIZE1 = 3'd0,
      MSIZE2 = 3'd1,
      MSIZE4 = 3'd2,
      MSIZE8 = 3'd3
   } msize_t;

   typedef logic [7:0] strobe_t;

   typedef struct packed {
      logic        valid;
      logic [63:0] addr;
      msize_t      size;
      strobe_t     strobe;
      logic [63:0] data;
   } dbus_req_t;

   typedef struct packed {
      logic        addr_ok;
      logic        data_ok;
      logic [63:0] data;
   } dbus_resp_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2,
      GAP  = 2'd3
   } dbus_resp_state_t;

   localparam int unsigned WORD_BYTES = 8;

   // Replace the strobed byte lanes of old_word with those of new_word.
   function automatic logic [63:0] byte_merge(input logic [63:0] old_word,
                                               input logic [63:0] new_word,
                                               input strobe_t     strobe);
      logic [63:0] merged;
      merged = old_word;
      for (int b = 0; b < WORD_BYTES; b++) begin
         if (strobe[b]) begin
            merged[b*8 +: 8] = new_word[b*8 +: 8];
         end else begin
            merged[b*8 +: 8] = old_word[b*8 +: 8];
         end
      end
      return merged;
   endfunction

endpackage

// File: rtl/dbus_sram_responder_if.sv
// Data-bus request/response bundle between an initiator and the responder.
interface dbus_sram_responder_if;
   import dbus_sram_responder_pkg::*;

   dbus_req_t  req;
   dbus_resp_t resp;

   modport master (output req, input resp);
   modport slave  (input req, output resp);
endinterface

// File: rtl/dbus_sram_responder_byte_sram.sv
// 64-bit wide SRAM with per-byte write enables: asynchronous read,
// synchronous write. Contents are never reset.
module dbus_sram_responder_byte_sram
   import dbus_sram_responder_pkg::*;
#(
   parameter int    ADDR_BITS = 12,
   parameter string INIT_FILE = ""
) (
   input  logic                 clk,
   input  logic [ADDR_BITS-1:0] addr_i,
   input  logic                 we_i,
   input  strobe_t              be_i,
   input  logic [63:0]          wdata_i,
   output logic [63:0]          rdata_o
);

   localparam int DEPTH = 2 ** ADDR_BITS;

   logic [63:0] mem_q [DEPTH];

   // Elaboration-time image: all zeros.
   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         mem_q[i] = 64'd0;
      end
   end

   // Byte-lane write at the clock edge.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[addr_i] <= byte_merge(mem_q[addr_i], wdata_i, be_i);
      end
   end

   assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dbus_sram_responder.sv
// Fixed-latency data-bus target backed by a byte-writable SRAM.
// Sequence per transaction: IDLE (accept) -> WAIT* -> RESP -> GAP.
module dbus_sram_responder
   import dbus_sram_responder_pkg::*;
#(
   parameter int          ADDR_BITS = 12,
   parameter logic [63:0] BASE_ADDR = 64'h0000_0000_8000_0000,
   parameter int          LATENCY   = 2,
   parameter string       INIT_FILE = ""
) (
   input  logic                  clk,
   input  logic                  reset,
   dbus_sram_responder_if.slave  dbus,
   output logic                  oor_o,
   output logic                  busy_o
);

   dbus_resp_state_t state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   dbus_req_t        cap_q, cap_d;

   logic                 resp_ok_s;
   logic                 we_s;
   logic [63:0]          offset_s;
   logic                 in_range_s;
   logic [ADDR_BITS-1:0] index_s;
   logic [63:0]          rdata_s;
   logic                 unused_s;

   // Word index and range check from the captured (authoritative) address.
   assign offset_s   = cap_q.addr - BASE_ADDR;
   assign in_range_s = (cap_q.addr >= BASE_ADDR) && (offset_s[63:ADDR_BITS+3] == '0);
   assign index_s    = offset_s[ADDR_BITS+2:3];
   assign unused_s   = ^{cap_q.valid, cap_q.size, offset_s[2:0]};

   // State, latency counter and captured request.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         cap_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cap_q   <= cap_d;
      end
   end

   // Next-state logic; the response is qualified by valid in the RESP cycle.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      cap_d     = cap_q;
      resp_ok_s = 1'b0;
      we_s      = 1'b0;
      case (state_q)
         IDLE: begin
            if (dbus.req.valid) begin
               cap_d   = dbus.req;
               cnt_d   = 4'(LATENCY - 1);
               state_d = (LATENCY == 1) ? RESP : WAIT;
            end else begin
               state_d = IDLE;
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
               state_d = RESP;
            end else begin
               state_d = WAIT;
            end
         end
         RESP: begin
            if (dbus.req.valid) begin
               resp_ok_s = 1'b1;
               we_s      = (cap_q.strobe != 8'h00) && in_range_s;
               state_d   = GAP;
            end else begin
               state_d = IDLE;
            end
         end
         GAP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Response outputs; read data is the pre-write word, zero when out of range.
   always_comb begin
      dbus.resp.addr_ok = resp_ok_s;
      dbus.resp.data_ok = resp_ok_s;
      if (resp_ok_s && in_range_s) begin
         dbus.resp.data = rdata_s;
      end else begin
         dbus.resp.data = 64'd0;
      end
      oor_o  = resp_ok_s && !in_range_s;
      busy_o = (state_q == WAIT) || (state_q == RESP);
   end

   dbus_sram_responder_byte_sram #(
      .ADDR_BITS (ADDR_BITS),
      .INIT_FILE (INIT_FILE)
   ) u_sram (
      .clk     (clk),
      .addr_i  (index_s),
      .we_i    (we_s),
      .be_i    (cap_q.strobe),
      .wdata_i (cap_q.data),
      .rdata_o (rdata_s)
   );

endmodule
